// File: rtl/mem_align_unit.sv
// Data-memory access unit: byte enables, store lane shifting and load extraction/extension.
// Define MISALIGN_SPLIT_EN to allow misaligned accesses (split into two beats when crossing a word).
module mem_align_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);
  // state | meaning
  // IDLE  | waiting for a request, req_ready high
  // BEAT0 | first (or only) bus beat outstanding
  // BEAT1 | second beat of a word-crossing access
  // RESP  | one-cycle response pulse

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int SH_W  = OFF_W + 4;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
  state_t state, state_nxt;

  logic              we_q, signed_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, acc_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_err_q, resp_valid_q;

  logic [OFF_W-1:0]   off;
  logic [3:0]         n_bytes;
  logic [ADDR_W-1:0]  base_addr;
  logic [BYTES-1:0]   lane_mask;
  logic [2*BYTES-1:0] mask_w;
  logic [SH_W-1:0]    sh0, sh1;
  logic               split, illegal;
  logic [DATA_W-1:0]  raw_load;

  assign off       = addr_q[OFF_W-1:0];
  assign n_bytes   = 4'd1 << size_q;
  assign base_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign sh0       = SH_W'(off) << 3;
  assign sh1       = (SH_W'(BYTES) - SH_W'(off)) << 3;

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < BYTES; i++) lane_mask[i] = (i < int'(n_bytes));
    mask_w = {{BYTES{1'b0}}, lane_mask} << off;
  end

`ifdef MISALIGN_SPLIT_EN
  assign split   = (5'(off) + 5'(n_bytes)) > 5'(BYTES);
  assign illegal = (DATA_W < 64) && (req_size == 2'b11);
`else
  logic [3:0] req_low;
  assign req_low = (4'd1 << req_size) - 4'd1;
  assign split   = 1'b0;
  assign illegal = ((DATA_W < 64) && (req_size == 2'b11)) ||
                   ((4'(req_addr[OFF_W-1:0]) & req_low) != 4'd0);
`endif

  // Mask the assembled bytes to n and sign/zero extend; a full-width load passes through.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw,
                                               input logic [3:0] n, input logic sgn);
    logic [DATA_W-1:0] res;
    logic              msb;
    res = raw;
    msb = 1'b0;
    if (int'(n) < BYTES) begin
      msb = sgn & raw[8*int'(n)-1];
      for (int i = 0; i < DATA_W; i++) if (i >= 8*int'(n)) res[i] = msb;
    end
    return res;
  endfunction

  assign raw_load = (state == BEAT1) ? (acc_q | (bus_rdata << sh1)) : (bus_rdata >> sh0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = illegal ? RESP : BEAT0;
      BEAT0:   if (bus_ready) state_nxt = split ? BEAT1 : RESP;
      BEAT1:   if (bus_ready) state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = '0;
    bus_wdata = '0;
    case (state)
      BEAT0: begin
        bus_valid = 1'b1;
        bus_we    = we_q;
        bus_addr  = base_addr;
        bus_be    = mask_w[BYTES-1:0];
        bus_wdata = wdata_q << sh0;
      end
      BEAT1: begin
        bus_valid = 1'b1;
        bus_we    = we_q;
        bus_addr  = base_addr + ADDR_W'(BYTES);
        bus_be    = mask_w[2*BYTES-1:BYTES];
        bus_wdata = wdata_q >> sh1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      acc_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= (state_nxt == RESP);
      if (state == IDLE && req_valid) begin
        we_q     <= req_we;
        signed_q <= req_signed;
        size_q   <= req_size;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        acc_q    <= '0;
        if (illegal) begin
          resp_err_q   <= 1'b1;
          resp_rdata_q <= '0;
        end
      end
      if (state == BEAT0 && bus_ready) acc_q <= raw_load;
      if ((state == BEAT0 && bus_ready && !split) || (state == BEAT1 && bus_ready)) begin
        resp_err_q   <= 1'b0;
        resp_rdata_q <= we_q ? '0 : extend(raw_load, n_bytes, signed_q);
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_mem_align_unit.sv
// Directed bench for mem_align_unit (DATA_W=32): byte-level reference model plus literal pins.
// Build with MISALIGN_SPLIT_EN defined to exercise split accesses; expectations follow the macro.
module tb_mem_align_unit;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NB = DW / 8;

  logic          clk, rst_n;
  logic          req_valid, req_ready, req_we, req_signed;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          bus_valid, bus_ready, bus_we;
  logic [AW-1:0] bus_addr;
  logic [NB-1:0] bus_be;
  logic [DW-1:0] bus_wdata, bus_rdata;
  logic          resp_valid, resp_err;
  logic [DW-1:0] resp_rdata;

  mem_align_unit #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [NB-1:0] be;
    logic          we;
    logic [DW-1:0] wdata;
  } beat_t;
  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
  } resp_t;

  beat_t exp_beats[$];
  resp_t exp_resp[$];
  logic [7:0] mem [0:2047];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  int last_lat = 0;
  logic [AW-1:0] last_addr;
  logic [NB-1:0] last_be;
  logic [DW-1:0] last_wdata, last_rdata;
  logic          last_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always_comb begin
    bus_rdata = '0;
    for (int i = 0; i < NB; i++) bus_rdata[8*i +: 8] = mem[11'(bus_addr + AW'(i))];
  end

  // Expected beats and response, worked out byte by byte from the addresses the access touches.
  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd, input int stall);
    int n, nbeats, lane, k;
    logic [AW-1:0] w0, a;
    logic [DW-1:0] ld;
    logic err;
    beat_t b [2];
    resp_t r;
    n = 1 << size;
    err = (n > NB);
`ifndef MISALIGN_SPLIT_EN
    if ((addr % AW'(n)) != 0) err = 1'b1;
`endif
    if (err) begin
      r.rdata = '0; r.err = 1'b1; r.lat = 1;
      exp_resp.push_back(r);
      return;
    end
    w0 = addr & ~AW'(NB-1);
    nbeats = 1;
    ld = '0;
    for (int i = 0; i < 2; i++) begin
      b[i].addr = w0 + AW'(NB*i); b[i].be = '0; b[i].we = we; b[i].wdata = '0;
    end
    for (int j = 0; j < n; j++) begin
      a = addr + AW'(j);
      k = ((a & ~AW'(NB-1)) == w0) ? 0 : 1;
      lane = int'(a % AW'(NB));
      b[k].be[lane] = 1'b1;
      b[k].wdata[8*lane +: 8] = wd[8*j +: 8];
      ld[8*j +: 8] = mem[a[10:0]];
      if (k == 1) nbeats = 2;
    end
    if (n < NB)
      for (int j = n; j < NB; j++) ld[8*j +: 8] = (sgn && ld[8*n-1]) ? 8'hFF : 8'h00;
    for (int i = 0; i < nbeats; i++) exp_beats.push_back(b[i]);
    r.rdata = we ? '0 : ld; r.err = 1'b0; r.lat = 1 + nbeats + stall;
    exp_resp.push_back(r);
  endtask

  // Compare process: 1 ns before each rising edge, after the driver has settled inputs.
  always begin
    @(negedge clk);
    cyc++;
    #4;
    if (rst_n) begin
      if (bus_valid) begin
        if (exp_beats.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: got addr %0h be %0b expected no beat", bus_addr, bus_be);
        end else begin
          check("beat_addr",  bus_addr,  exp_beats[0].addr);
          check("beat_be",    bus_be,    exp_beats[0].be);
          check("beat_we",    bus_we,    exp_beats[0].we);
          check("beat_wdata", bus_wdata, exp_beats[0].wdata);
          if (bus_ready) begin
            last_addr = bus_addr; last_be = bus_be; last_wdata = bus_wdata;
            void'(exp_beats.pop_front());
          end
        end
      end
      if (resp_valid) begin
        if (exp_resp.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_resp: got resp_valid 1 expected 0");
        end else begin
          last_lat = cyc - acc_cyc;
          last_rdata = resp_rdata; last_err = resp_err;
          check("resp_rdata",   resp_rdata, exp_resp[0].rdata);
          check("resp_err",     resp_err,   exp_resp[0].err);
          check("resp_latency", last_lat,   exp_resp[0].lat);
          check("beats_left",   exp_beats.size(), 0);
          void'(exp_resp.pop_front());
        end
      end
    end
  end

  task automatic do_access(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd, input int stall);
    int stall_left;
    int c;
    model(we, size, sgn, addr, wd, stall);
    @(negedge clk); #2;
    check("req_ready_idle", req_ready, 1'b1);
    acc_cyc = cyc;
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wd;
    @(negedge clk); #2;
    req_valid = 1'b0;
    stall_left = stall;
    c = 0;
    while (exp_resp.size() > 0 && c < 60) begin
      if (bus_valid && stall_left > 0) begin
        bus_ready = 1'b0; stall_left--;
      end else bus_ready = 1'b1;
      if (bus_valid && bus_ready && bus_we)
        for (int i = 0; i < NB; i++)
          if (bus_be[i]) mem[11'(bus_addr + AW'(i))] = bus_wdata[8*i +: 8];
      @(negedge clk); #2;
      c++;
    end
    if (exp_resp.size() > 0) begin
      total++; bad++;
      $display("FAIL resp_timeout: got no response after %0d cycles expected one", c);
      exp_resp.delete(); exp_beats.delete();
    end
    bus_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; bus_ready = 1'b1;
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 37 + 5);
    repeat (2) @(negedge clk);
    #2;
    check("rst_req_ready",  req_ready,  1'b1);
    check("rst_bus_valid",  bus_valid,  1'b0);
    check("rst_bus_we",     bus_we,     1'b0);
    check("rst_bus_be",     bus_be,     '0);
    check("rst_bus_addr",   bus_addr,   '0);
    check("rst_bus_wdata",  bus_wdata,  '0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_err",   resp_err,   1'b0);
    check("rst_resp_rdata", resp_rdata, '0);
    rst_n = 1'b1;

    do_access(1'b1, 2'b00, 1'b0, 32'h103, 32'hAB, 0);
    check("sb_addr",  last_addr, 32'h100);
    check("sb_be",    last_be,   4'b1000);
    check("sb_lane3", last_wdata[31:24], 8'hAB);
    check("sb_err",   last_err,  1'b0);
    check("sb_lat",   last_lat,  2);

    mem[11'h202] = 8'h01; mem[11'h203] = 8'h80;
    do_access(1'b0, 2'b01, 1'b1, 32'h202, '0, 0);
    check("lh_signed", last_rdata, 32'hFFFF_8001);
    do_access(1'b0, 2'b01, 1'b0, 32'h202, '0, 0);
    check("lh_unsigned", last_rdata, 32'h0000_8001);

    do_access(1'b1, 2'b10, 1'b0, 32'h4, 32'h1234_5678, 3);
    check("sw_stall_lat", last_lat, 5);
    do_access(1'b0, 2'b10, 1'b0, 32'h4, '0, 0);
    check("lw_readback", last_rdata, 32'h1234_5678);
    do_access(1'b0, 2'b00, 1'b1, 32'h103, '0, 0);
    check("lb_signed", last_rdata, 32'hFFFF_FFAB);

    mem[11'h1FE] = 8'hAA; mem[11'h1FF] = 8'hBB; mem[11'h200] = 8'hCC; mem[11'h201] = 8'hDD;
    do_access(1'b0, 2'b10, 1'b0, 32'h1FE, '0, 0);
`ifdef MISALIGN_SPLIT_EN
    check("split_rdata", last_rdata, 32'hDDCC_BBAA);
    check("split_err",   last_err,   1'b0);
    check("split_lat",   last_lat,   3);
`else
    check("misal_rdata", last_rdata, 32'h0);
    check("misal_err",   last_err,   1'b1);
    check("misal_lat",   last_lat,   1);
`endif

    do_access(1'b0, 2'b11, 1'b0, 32'h10, '0, 0);
    check("dword_err",   last_err,   1'b1);
    check("dword_rdata", last_rdata, 32'h0);

    do_access(1'b0, 2'b01, 1'b0, 32'h301, '0, 0);
`ifdef MISALIGN_SPLIT_EN
    check("lh_off1_be", last_be, 4'b0110);
`else
    check("lh_off1_err", last_err, 1'b1);
`endif

    do_access(1'b1, 2'b01, 1'b0, 32'h206, 32'hBEEF, 1);
    do_access(1'b0, 2'b00, 1'b0, 32'h207, '0, 0);
    check("lbu_readback", last_rdata, 32'h0000_00BE);
    do_access(1'b0, 2'b01, 1'b1, 32'h206, '0, 2);
    check("lh_neg", last_rdata, 32'hFFFF_BEEF);
    do_access(1'b1, 2'b10, 1'b0, 32'h3FF, 32'h1122_3344, 0);
    do_access(1'b0, 2'b10, 1'b0, 32'h3FF, '0, 1);
    do_access(1'b0, 2'b00, 1'b0, 32'h3FF, '0, 0);

    // Abort an access while its first beat is stalled.
    model(1'b0, 2'b10, 1'b0, 32'h8, '0, 100);
    @(negedge clk); #2;
    bus_ready = 1'b0;
    acc_cyc = cyc;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h8;
    @(negedge clk); #2;
    req_valid = 1'b0;
    check("abort_beat_live", bus_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_bus_valid",  bus_valid,  1'b0);
    check("abort_req_ready",  req_ready,  1'b1);
    check("abort_bus_be",     bus_be,     '0);
    check("abort_bus_addr",   bus_addr,   '0);
    check("abort_resp_valid", resp_valid, 1'b0);
    exp_beats.delete(); exp_resp.delete();
    @(negedge clk); #2;
    rst_n = 1'b1; bus_ready = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    check("post_abort_ready", req_ready, 1'b1);
    do_access(1'b0, 2'b10, 1'b0, 32'h4, '0, 0);
    check("post_abort_lw", last_rdata, 32'h1234_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
